gpu_command_executor: RTL and testbench

//   Consumer stage directly downstream of the byte-serial instruction buffer. It takes each

---
 rtl/gpu_pkg.sv | 35 +++
 rtl/rect_scan_counter.sv | 56 +++++
 rtl/gpu_command_executor.sv | 134 +++++++++++++
 tb/tb_gpu_command_executor.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared opcodes, screen defaults, FSM states and
// the extent clipping helper for the GPU command executor.
package gpu_pkg;

  localparam int H_RES_D  = 160;
  localparam int V_RES_D  = 120;
  localparam int ADDR_W_D = 15;
  localparam int COLOR_W  = 8;
  localparam int DIM_W    = 9;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_SET_COLOR  = 8'h01;
  localparam logic [7:0] OP_SET_CURSOR = 8'h02;
  localparam logic [7:0] OP_PUT_PIXEL  = 8'h03;
  localparam logic [7:0] OP_FILL_RECT  = 8'h04;
  localparam logic [7:0] OP_CLEAR      = 8'h05;

  typedef enum logic {
    S_IDLE,
    S_DRAW
  } state_e;

  // Visible run length from pos: min(len, res-pos), 0 if off-screen.
  function automatic logic [DIM_W-1:0] clip_ext(
    input logic [DIM_W-1:0] pos,
    input logic [DIM_W-1:0] len,
    input int               res
  );
    logic [DIM_W-1:0] room;
    if (int'(pos) >= res) return '0;
    room = DIM_W'(res - int'(pos));
    return (len < room) ? len : room;
  endfunction

endpackage

// File: rtl/rect_scan_counter.sv
// rect_scan_counter: row-major address walk over a clipped
// rectangle; row base advances by H_RES, so no loop multiplier.
module rect_scan_counter #(
  parameter int H_RES  = 160,
  parameter int ADDR_W = 15,
  parameter int DIM_W  = 9
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [DIM_W-1:0]  x_i,
  input  logic [DIM_W-1:0]  y_i,
  input  logic [DIM_W-1:0]  w_i,
  input  logic [DIM_W-1:0]  h_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] base_q;
  logic [DIM_W-1:0]  col_q;
  logic [DIM_W-1:0]  row_q;
  logic [DIM_W-1:0]  w_q;
  logic [DIM_W-1:0]  h_q;
  logic              col_end;

  assign col_end = col_q == w_q - DIM_W'(1);
  assign addr_o  = base_q + ADDR_W'(col_q);
  assign last_o  = col_end && (row_q == h_q - DIM_W'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      w_q    <= '0;
      h_q    <= '0;
    end else if (load_i) begin
      base_q <= ADDR_W'(y_i) * ADDR_W'(H_RES)
              + ADDR_W'(x_i);
      col_q  <= '0;
      row_q  <= '0;
      w_q    <= w_i;
      h_q    <= h_i;
    end else if (adv_i) begin
      if (col_end) begin
        col_q  <= '0;
        row_q  <= row_q + DIM_W'(1);
        base_q <= base_q + ADDR_W'(H_RES);
      end else begin
        col_q  <= col_q + DIM_W'(1);
      end
    end
  end

endmodule

// File: rtl/gpu_command_executor.sv
// gpu_command_executor: decodes buffered drawing instructions,
// holds cursor/colour and drives framebuffer pixel writes.
module gpu_command_executor #(
  parameter int H_RES   = gpu_pkg::H_RES_D,
  parameter int V_RES   = gpu_pkg::V_RES_D,
  parameter int ADDR_W  = gpu_pkg::ADDR_W_D,
  parameter int COLOR_W = gpu_pkg::COLOR_W
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [31:0]        i_instruction,
  input  logic               i_valid,
  output logic               o_busy,
  output logic               o_overrun,
  output logic               o_illegal,
  output logic               o_fb_we,
  output logic [ADDR_W-1:0]  o_fb_addr,
  output logic [COLOR_W-1:0] o_fb_data,
  input  logic               i_fb_ready
);
  import gpu_pkg::*;

  state_e             state_q;
  logic [7:0]         cx_q, cy_q;
  logic [7:0]         nx, ny;
  logic [7:0]         op, a2, a1;
  logic [COLOR_W-1:0] color_q;
  logic               overrun_q, illegal_q;
  logic [DIM_W-1:0]   ld_x, ld_y, ld_w, ld_h;
  logic               go, start, accept;
  logic               scan_last, wrap_x;
  logic               unused_hi;

  assign op        = i_instruction[7:0];
  assign a1        = i_instruction[15:8];
  assign a2        = i_instruction[23:16];
  assign unused_hi = ^i_instruction[31:24];

  assign go     = i_valid && state_q == S_IDLE;
  assign start  = go && ld_w != '0 && ld_h != '0;
  assign accept = o_fb_we && i_fb_ready;

  assign o_busy    = state_q == S_DRAW;
  assign o_fb_we   = state_q == S_DRAW;
  assign o_fb_data = color_q;
  assign o_overrun = overrun_q;
  assign o_illegal = illegal_q;

  // Extents are clipped here so the scan never visits off-screen pixels.
  always_comb begin
    ld_x = DIM_W'(cx_q);
    ld_y = DIM_W'(cy_q);
    ld_w = '0;
    ld_h = '0;
    unique case (1'b1)
      op == OP_PUT_PIXEL: begin
        ld_w = clip_ext(ld_x, DIM_W'(1), H_RES);
        ld_h = clip_ext(ld_y, DIM_W'(1), V_RES);
      end
      op == OP_FILL_RECT: begin
        ld_w = clip_ext(ld_x, DIM_W'(a2), H_RES);
        ld_h = clip_ext(ld_y, DIM_W'(a1), V_RES);
      end
      op == OP_CLEAR: begin
        ld_x = '0;
        ld_y = '0;
        ld_w = DIM_W'(H_RES);
        ld_h = DIM_W'(V_RES);
      end
      default: ;
    endcase
  end

  assign wrap_x = DIM_W'(cx_q) + DIM_W'(1)
               == DIM_W'(H_RES);
  assign nx = wrap_x ? '0 : cx_q + 8'd1;
  assign ny = !wrap_x ? cy_q
            : (DIM_W'(cy_q) + DIM_W'(1)
               == DIM_W'(V_RES)) ? '0
            : cy_q + 8'd1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      cx_q      <= '0;
      cy_q      <= '0;
      color_q   <= '0;
      overrun_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      overrun_q <= i_valid && state_q == S_DRAW;
      illegal_q <= go && op > OP_CLEAR;
      unique case (state_q)
        S_IDLE: if (go) begin
          unique case (1'b1)
            op == OP_SET_COLOR:
              color_q <= COLOR_W'(a1);
            op == OP_SET_CURSOR: begin
              cx_q <= a2;
              cy_q <= a1;
            end
            op == OP_PUT_PIXEL: begin
              cx_q <= nx;
              cy_q <= ny;
            end
            default: ;
          endcase
          if (start) state_q <= S_DRAW;
        end
        S_DRAW:
          if (accept && scan_last) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  rect_scan_counter #(
    .H_RES  (H_RES),
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_scan (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .load_i (start),
    .adv_i  (accept),
    .x_i    (ld_x),
    .y_i    (ld_y),
    .w_i    (ld_w),
    .h_i    (ld_h),
    .addr_o (o_fb_addr),
    .last_o (scan_last)
  );

endmodule

// File: tb/tb_gpu_command_executor.sv
// tb_gpu_command_executor: directed and random command stream
// checked against a pixel-list reference model.
module tb_gpu_command_executor;
  localparam int H = 160;
  localparam int V = 120;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] instr = '0;
  logic        busy, ovr, ill, we;
  logic [14:0] addr;
  logic [7:0]  data;

  int passed = 0;
  int total  = 0;
  bit last_ok;
  int rmode = 0;
  int busy_cnt, ovr_cnt, ill_cnt;
  int m_cx = 0, m_cy = 0, m_col = 0;
  bit stall_q = 0;
  logic [22:0] held;
  logic [22:0] got_q[$];
  logic [22:0] exp_q[$];

  always #5 clk = ~clk;

  gpu_command_executor dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_instruction (instr),
    .i_valid       (valid),
    .o_busy        (busy),
    .o_overrun     (ovr),
    .o_illegal     (ill),
    .o_fb_we       (we),
    .o_fb_addr     (addr),
    .o_fb_data     (data),
    .i_fb_ready    (ready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    last_ok = (obs === exp);
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h",
                tag, obs, exp);
  endtask

  function automatic logic [22:0] gotat(input int i);
    if (i >= got_q.size()) return 23'h7fffff;
    return got_q[i];
  endfunction

  function automatic void push_px(input int x,
                                  input int y);
    if (x < H && y < V)
      exp_q.push_back({15'(y * H + x), 8'(m_col)});
  endfunction

  task automatic model(input logic [31:0] ins,
                       output int n_ill);
    int op, a2, a1;
    op = int'(ins[7:0]);
    a1 = int'(ins[15:8]);
    a2 = int'(ins[23:16]);
    n_ill = 0;
    case (op)
      0: ;
      1: m_col = a1;
      2: begin m_cx = a2; m_cy = a1; end
      3: begin
        push_px(m_cx, m_cy);
        m_cx = (m_cx + 1) % 256;
        if (m_cx == H) begin
          m_cx = 0;
          m_cy = (m_cy + 1 == V) ? 0 : (m_cy + 1) % 256;
        end
      end
      4: for (int y = 0; y < a1; y++)
           for (int x = 0; x < a2; x++)
             push_px(m_cx + x, m_cy + y);
      5: for (int y = 0; y < V; y++)
           for (int x = 0; x < H; x++)
             push_px(x, y);
      default: n_ill = 1;
    endcase
  endtask

  task automatic run_cmd(input string tag,
                         input logic [31:0] ins,
                         input logic [31:0] inj,
                         input int rm);
    int n, e_ill;
    rmode = rm;
    exp_q.delete();
    got_q.delete();
    busy_cnt = 0;
    ovr_cnt  = 0;
    ill_cnt  = 0;
    model(ins, e_ill);
    @(negedge clk);
    instr = ins;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    n = 0;
    while (busy && n < 50000) begin
      if (inj != 0 && n == 3) begin
        instr = inj;
        valid = 1'b1;
      end
      @(negedge clk);
      valid = 1'b0;
      n++;
    end
    @(negedge clk);
    #1;
    chk({tag, " done"}, 32'(busy), 32'd0);
    chk({tag, " nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s px%0d", tag, i),
          32'(gotat(i)), 32'(exp_q[i]));
      if (!last_ok) break;
    end
    chk({tag, " illegal"}, ill_cnt, e_ill);
    chk({tag, " overrun"}, ovr_cnt, (inj != 0) ? 1 : 0);
    if (rm == 0)
      chk({tag, " busy"}, busy_cnt, exp_q.size());
  endtask

  initial begin
    logic [31:0] ins;
    fork
      forever begin
        @(negedge clk);
        if (stall_q)
          chk("hold", {8'b0, we, addr, data},
              {8'b0, 1'b1, held});
        if (rmode == 0)      ready = 1'b1;
        else if (rmode == 1) ready = ~ready;
        else                 ready = 1'($urandom);
        stall_q = we && !ready;
        held = {addr, data};
        if (we && ready) got_q.push_back({addr, data});
        busy_cnt += int'(busy);
        ovr_cnt  += int'(ovr);
        ill_cnt  += int'(ill);
      end
    join_none

    repeat (2) @(negedge clk);
    #1;
    chk("rst out", {busy, ovr, ill, we, addr, data},
        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    run_cmd("t1col", 32'h000AE301, 0, 0);
    run_cmd("t1cur", 32'h00050302, 0, 0);
    run_cmd("t1put", 32'h00000003, 0, 0);
    chk("t1 addr", 32'(gotat(0)), {9'b0, 15'd485, 8'hE3});
    run_cmd("t1nxt", 32'h00000003, 0, 0);
    chk("t1 x6", 32'(gotat(0)), {9'b0, 15'd486, 8'hE3});

    run_cmd("t2cur", 32'h009F7702, 0, 0);
    run_cmd("t2put", 32'h00000003, 0, 0);
    chk("t2 addr", 32'(gotat(0) >> 8), 32'd19199);
    run_cmd("t2wrp", 32'h00000003, 0, 0);
    chk("t2 wrap", 32'(gotat(0) >> 8), 32'd0);

    run_cmd("t3cur", 32'h000A1402, 0, 0);
    run_cmd("t3rect", 32'h00030204, 0, 0);
    chk("t3 a0", 32'(gotat(0) >> 8), 32'd3210);
    chk("t3 a3", 32'(gotat(3) >> 8), 32'd3370);
    chk("t3 a5", 32'(gotat(5) >> 8), 32'd3372);
    run_cmd("t4stall", 32'h00030204, 0, 1);

    run_cmd("t5cur", 32'h009B0002, 0, 0);
    run_cmd("t5clip", 32'h000A0104, 0, 0);
    chk("t5 cnt", got_q.size(), 32'd5);
    run_cmd("t5off", 32'h00C80002, 0, 0);
    run_cmd("t5none", 32'h00040104, 0, 0);
    chk("t5 zero", got_q.size(), 32'd0);

    run_cmd("t6cur", 32'h00000002, 0, 0);
    run_cmd("t6ovr", 32'h00140204, 32'h00005501, 2);
    run_cmd("t6ill", 32'h0000007F, 0, 0);

    run_cmd("clrcol", 32'h00001C01, 0, 0);
    run_cmd("clear", 32'h00000005, 0, 0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: ins = {16'h0, 8'($urandom), 8'h01};
        1: ins = {8'h0, 8'($urandom_range(0, 199)),
                  8'($urandom_range(0, 139)), 8'h02};
        2: ins = 32'h00000003;
        3: ins = {8'h0, 8'($urandom_range(0, 12)),
                  8'($urandom_range(0, 12)), 8'h04};
        4: ins = {8'($urandom), 16'h0,
                  8'($urandom_range(6, 255))};
        default: ins = 32'h0;
      endcase
      run_cmd($sformatf("rnd%0d", k), ins, 0,
              $urandom_range(0, 2));
    end

    run_cmd("rcur", 32'h000A1402, 0, 0);
    run_cmd("rcol", 32'h00003301, 0, 0);
    @(negedge clk);
    instr = 32'h00140504;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst we", {30'b0, we, busy}, 32'd0);
    chk("rst fb", {9'b0, addr, data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_cx  = 0;
    m_cy  = 0;
    m_col = 0;
    #1;
    run_cmd("rput", 32'h00000003, 0, 0);
    chk("rst state", 32'(gotat(0)), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
